// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line front end.
package ps2_pkg;

   // Transfer phases of a single host-to-device command byte.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SEND,
      ST_ACK,
      ST_RELEASE
   } ps2_state_e;

   // Common keyboard commands and the device acknowledge byte.
   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

   // Larger of two counts, used to size the shared cycle counter.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock. Lines idle high, so the flops reset high
// and no spurious edge appears when reset is released.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_pin_i,
   input  logic data_pin_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic clk_fall_o
);

   logic [1:0] clk_ff_q;
   logic [1:0] data_ff_q;
   logic       clk_prev_q;

   // Synchronizer chains and previous synced clock level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_ff_q   <= 2'b11;
         data_ff_q  <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_ff_q   <= {clk_ff_q[0], clk_pin_i};
         data_ff_q  <= {data_ff_q[0], data_pin_i};
         clk_prev_q <= clk_ff_q[1];
      end
   end

   assign clk_sync_o  = clk_ff_q[1];
   assign data_sync_o = data_ff_q[1];
   // Combinational so the consumer acts on the third clk edge after the pin falls.
   assign clk_fall_o  = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the request-to-send,
// shifts a command byte out on device clock falls, checks the ACK and reports
// completion (success, missing ACK or timeout) with a single done pulse.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC = 12_000,
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int unsigned CNT_W = $clog2(max_u(INHIBIT_CYC, TIMEOUT_CYC) + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t INHIBIT_LAST = cnt_t'(INHIBIT_CYC - 1);
   localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYC - 1);

   ps2_state_e state_q, state_d;
   logic [8:0] shift_q, shift_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   cnt_t       cnt_q, cnt_d;
   logic       clk_oe_q, clk_oe_d;
   logic       data_oe_q, data_oe_d;
   logic       nack_q, nack_d;
   logic       done_q, done_d;
   logic       ack_err_q, ack_err_d;
   logic       timeout_q, timeout_d;

   logic clk_sync, data_sync, clk_fall, fall;
   logic abort;
   cnt_t cnt_inc;

   ps2_line_sync u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_pin_i   (ps2_clk_i),
      .data_pin_i  (ps2_data_i),
      .clk_sync_o  (clk_sync),
      .data_sync_o (data_sync),
      .clk_fall_o  (clk_fall)
   );

   // Device clock edges only matter once the device owns the clock.
   assign fall    = clk_fall & ((state_q == ST_SEND) | (state_q == ST_ACK));
   assign cnt_inc = cnt_q + cnt_t'(1);

   // Next-state and output decode; pad enables and status flags are registered.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      nack_d    = nack_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;
      abort     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            // The done cycle still reports busy, so a start there is dropped.
            if (start && !done_q) begin
               shift_d   = {~^din, din};
               bit_cnt_d = 4'd0;
               cnt_d     = '0;
               nack_d    = 1'b0;
               clk_oe_d  = 1'b1;
               state_d   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;   // start bit, held through the request cycle
               state_d   = ST_REQ;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_REQ: begin
            cnt_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (fall) begin
               cnt_d     = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  data_oe_d = 1'b0;   // stop bit: line released
                  state_d   = ST_ACK;
               end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = {1'b0, shift_q[8:1]};
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_ACK: begin
            if (fall) begin
               cnt_d   = '0;
               nack_d  = data_sync;
               state_d = ST_RELEASE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RELEASE: begin
            if (clk_sync && data_sync) begin
               done_d    = 1'b1;
               ack_err_d = nack_q;
               state_d   = ST_IDLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
      if (abort) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b1;
         timeout_d = 1'b1;
         state_d   = ST_IDLE;
      end
   end

   // State and datapath registers; reset releases both lines immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         nack_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         nack_q    <= nack_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         timeout_q <= timeout_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign busy        = (state_q != ST_IDLE) | done_q;
   assign done        = done_q;
   assign ack_err     = ack_err_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a behavioural keyboard that
// clocks the frame in, samples each bit and optionally ACKs, stalls or holds data.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 20;
   localparam int TMO  = 200;
   localparam int HALF = 25;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] din = 8'h00;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_i, ps2_data_i;
   logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;

   // Wired-AND open-drain lines shared by host and device.
   assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .din         (din),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .ack_err     (ack_err),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      bit         ack;
      int         stop_after;   // device stops clocking after this many pulses (0 = full frame)
      int         hold_low;     // extra cycles device holds data low after ACK
      bit         dup;          // second start (8'hFF) during inhibit
      bit         exp_ack_err;
      bit         exp_timeout;
   } vec_t;

   vec_t vecs[5];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   last_fall_cyc = 0;
   logic last_ack_err = 1'b0;
   logic last_timeout = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference frame as the device sees it: d0..d7, odd parity, stop.
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Done-pulse monitor: captures flags and checks busy/pad behaviour around done.
   initial begin
      bit after_done;
      after_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (done) begin
               done_cnt++;
               done_cyc     = cyc;
               last_ack_err = ack_err;
               last_timeout = timeout;
               chk("busy_in_done", busy, 1);
               chk("oe_in_done", ps2_clk_oe | ps2_data_oe, 0);
               after_done = 1'b1;
            end else begin
               if (after_done) chk("busy_after_done", busy, 0);
               after_done = 1'b0;
               chk("flags_outside_done", ack_err | timeout, 0);
            end
         end
      end
   end

   // Behavioural keyboard: clock pulses of 2*HALF cycles, samples mid-high.
   task automatic device(input bit ack, input int stop_after, input int hold_low,
                         output logic [9:0] smp, output int nsmp);
      int npulses;
      smp = '0;
      nsmp = 0;
      npulses = (stop_after > 0) ? stop_after : 11;
      for (int k = 1; k <= npulses; k++) begin
         dev_clk_low = 1'b1;
         last_fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (HALF / 2) @(negedge clk);
         if (k <= 10) begin
            smp[k-1] = ps2_data_i;
            nsmp = k;
         end
         if (k == 10 && ack) dev_data_low = 1'b1;
         repeat (HALF - HALF / 2) @(negedge clk);
      end
      if (npulses == 11 && ack) begin
         repeat (hold_low) @(negedge clk);
         dev_data_low = 1'b0;
      end
   endtask

   task automatic run_xfer(input vec_t v);
      int         d0, n, nsmp, exp_n, lat;
      logic [9:0] smp, expf, mask;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      d0 = done_cnt;
      @(negedge clk);
      din = v.din;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("clk_oe_after_start", ps2_clk_oe, 1);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         if (v.dup && n == 5) begin
            din = PS2_CMD_RESET;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("inhibit_len", n, INH);
      chk("start_bit_at_release", ps2_data_oe, 1);
      repeat (10) @(negedge clk);
      device(v.ack, v.stop_after, v.hold_low, smp, nsmp);
      n = 0;
      while (done_cnt == d0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("done_pulses", done_cnt - d0, 1);
      chk("ack_err", last_ack_err, v.exp_ack_err);
      chk("timeout", last_timeout, v.exp_timeout);
      exp_n = (v.stop_after > 0 && v.stop_after < 10) ? v.stop_after : 10;
      chk("bits_seen", nsmp, exp_n);
      mask = '0;
      for (int i = 0; i < 10; i++) if (i < nsmp) mask[i] = 1'b1;
      expf = frame_of(v.din);
      chk("frame", smp & mask, expf & mask);
      if (v.exp_timeout) begin
         lat = done_cyc - last_fall_cyc;
         chk("timeout_latency_ok", (lat >= TMO && lat <= TMO + 10) ? 1 : 0, 1);
      end
      $display("xfer din=%02h ack=%0d stop_after=%0d hold=%0d dup=%0d bits=%03h ack_err=%0d timeout=%0d",
               v.din, v.ack, v.stop_after, v.hold_low, v.dup, smp, last_ack_err, last_timeout);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic act;
      vec_t v;
      vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 0, 0,   1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h00,           1'b0, 0, 0,   1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'hA5,           1'b1, 4, 0,   1'b0, 1'b0, 1'b1};
      vecs[3] = '{PS2_CMD_ENABLE,  1'b1, 0, 0,   1'b1, 1'b0, 1'b0};
      vecs[4] = '{PS2_ACK_BYTE,    1'b1, 0, 300, 1'b0, 1'b0, 1'b1};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack_err", ack_err, 0);
      chk("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of the inhibit phase.
      din = PS2_CMD_RESET;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("clk_oe_before_reset", ps2_clk_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_clk_oe", ps2_clk_oe, 0);
      chk("async_rst_data_oe", ps2_data_oe, 0);
      chk("async_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      act = 1'b0;
      repeat (100) begin
         @(negedge clk);
         act = act | ps2_clk_oe | ps2_data_oe | busy | done;
      end
      chk("quiet_after_reset", act, 0);
      $display("reset mid-inhibit quiet=%0d", !act);

      for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

      for (int r = 0; r < 6; r++) begin
         v.din        = 8'($urandom_range(0, 255));
         v.ack        = 1'($urandom_range(0, 1));
         v.stop_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
         v.hold_low   = 0;
         v.dup        = 1'b0;
         v.exp_timeout = (v.stop_after > 0);
         v.exp_ack_err = (v.stop_after == 0) && !v.ack;
         run_xfer(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
